// File: rtl/hamming12_8_pkg.sv
// Shared constants and helpers for the Hamming(12,8) codec.
// Position p (1..12) of the codeword lives at bit index p-1.
package hamming12_8_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;

  // Each parity/syndrome bit covers the positions whose number has bit k set.
  localparam logic [CODE_W-1:0] P1_MASK = 12'h555;
  localparam logic [CODE_W-1:0] P2_MASK = 12'h666;
  localparam logic [CODE_W-1:0] P4_MASK = 12'h878;
  localparam logic [CODE_W-1:0] P8_MASK = 12'hF80;

  // Parity bit indices for P1, P2, P4, P8.
  localparam logic [3:0] PAR_IDX [4] = '{4'd0, 4'd1, 4'd3, 4'd7};

  // Bit index carrying d0..d7.
  localparam logic [3:0] DATA_IDX [DATA_W] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_CORRECTED = 2'b01,
    ST_UNCORR    = 2'b10
  } status_t;

  // Spread a byte into its data slots, leaving every parity slot zero.
  function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] w;
    w = '0;
    w[DATA_IDX[0]] = d[0];
    w[DATA_IDX[1]] = d[1];
    w[DATA_IDX[2]] = d[2];
    w[DATA_IDX[3]] = d[3];
    w[DATA_IDX[4]] = d[4];
    w[DATA_IDX[5]] = d[5];
    w[DATA_IDX[6]] = d[6];
    w[DATA_IDX[7]] = d[7];
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] w);
    logic [DATA_W-1:0] d;
    d[0] = w[DATA_IDX[0]];
    d[1] = w[DATA_IDX[1]];
    d[2] = w[DATA_IDX[2]];
    d[3] = w[DATA_IDX[3]];
    d[4] = w[DATA_IDX[4]];
    d[5] = w[DATA_IDX[5]];
    d[6] = w[DATA_IDX[6]];
    d[7] = w[DATA_IDX[7]];
    return d;
  endfunction

endpackage

// File: rtl/hamming12_8_parity.sv
// Combinational parity/syndrome generator: syn = {S8,S4,S2,S1} over a 12-bit word.
// With parity slots zero this yields the parity bits; over a received word it is the syndrome.
module hamming12_8_parity
  import hamming12_8_pkg::*;
(
  input  logic [CODE_W-1:0] word,
  output logic [3:0]        syn
);

  assign syn = {^(word & P8_MASK), ^(word & P4_MASK), ^(word & P2_MASK), ^(word & P1_MASK)};

endmodule

// File: rtl/hamming_coder12_8.sv
// Hamming(12,8) SEC codec: registered encoder (data -> hc_out) and decoder (hc_in -> q).
// Optional macro HC_STATUS_EN adds the registered 2-bit err status output.
module hamming_coder12_8
  import hamming12_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] hc_out,
  input  logic [CODE_W-1:0] hc_in,
`ifdef HC_STATUS_EN
  output logic [1:0]        err,
`endif
  output logic [DATA_W-1:0] q
);

  // There is no handshake: both paths capture their input on every rising edge.
  logic [CODE_W-1:0] enc_word;
  logic [3:0]        enc_syn;
  logic [CODE_W-1:0] enc_code;
  logic [3:0]        dec_syn;
  logic [CODE_W-1:0] dec_fixed;
  logic [DATA_W-1:0] dec_data;

  assign enc_word = place_data(data);

  hamming12_8_parity u_enc_parity (
    .word (enc_word),
    .syn  (enc_syn)
  );

  hamming12_8_parity u_dec_parity (
    .word (hc_in),
    .syn  (dec_syn)
  );

  always_comb begin
    enc_code = enc_word;
    enc_code[PAR_IDX[0]] = enc_syn[0];
    enc_code[PAR_IDX[1]] = enc_syn[1];
    enc_code[PAR_IDX[2]] = enc_syn[2];
    enc_code[PAR_IDX[3]] = enc_syn[3];
  end

  // Syndromes 13..15 point past the word, so the input passes through untouched.
  always_comb begin
    dec_fixed = hc_in;
    if (dec_syn != 4'd0 && dec_syn <= 4'd12) begin
      dec_fixed[dec_syn - 4'd1] = ~hc_in[dec_syn - 4'd1];
    end
  end

  assign dec_data = extract_data(dec_fixed);

`ifdef HC_STATUS_EN
  status_t dec_status;

  always_comb begin
    dec_status = ST_OK;
    if (dec_syn > 4'd12) begin
      dec_status = ST_UNCORR;
    end else if (dec_syn != 4'd0) begin
      dec_status = ST_CORRECTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= ST_OK;
    end else begin
      err <= dec_status;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_out <= '0;
      q      <= '0;
    end else begin
      hc_out <= enc_code;
      q      <= dec_data;
    end
  end

endmodule

// File: tb/tb_hamming_coder12_8.sv
// Directed self-checking bench for hamming_coder12_8 (HC_STATUS_EN enables err checks).
module tb_hamming_coder12_8;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic [11:0] hc_out;
  logic [11:0] hc_in;
  logic [7:0]  q;
`ifdef HC_STATUS_EN
  logic [1:0]  err;
`endif

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  hamming_coder12_8 dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .hc_out (hc_out),
    .hc_in  (hc_in),
`ifdef HC_STATUS_EN
    .err    (err),
`endif
    .q      (q)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_err(input string tag, input logic [1:0] expv);
`ifdef HC_STATUS_EN
    check(tag, {10'd0, err}, {10'd0, expv});
`else
    if (expv === 2'bxx) $display("unused %s", tag);
`endif
  endtask

  logic [7:0]  enc_data [4] = '{8'h00, 8'h01, 8'hA5, 8'hFF};
  logic [11:0] enc_code [4] = '{12'h000, 12'h007, 12'hA27, 12'hF77};
  logic [7:0]  exp_v;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    data   = 8'h00;
    hc_in  = 12'h000;

    // Reset held for 10 cycles with random inputs.
    for (int i = 0; i < 10; i++) begin
      data  = 8'($urandom_range(0, 255));
      hc_in = 12'($urandom_range(0, 4095));
      tick();
      check("rst_hc_out", hc_out, 12'h000);
      check("rst_q", {4'd0, q}, 12'h000);
      check_err("rst_err", 2'b00);
    end
    rst = 1'b0;

    // Encode table, one cycle latency.
    hc_in = 12'h000;
    for (int i = 0; i < 4; i++) begin
      data = enc_data[i];
      tick();
      check("enc", hc_out, enc_code[i]);
    end

    // Clean A5 codeword decodes with no error.
    hc_in = 12'hA27;
    tick();
    check("dec_clean_q", {4'd0, q}, 12'h0A5);
    check_err("dec_clean_err", 2'b00);

    // Index 5 flipped.
    hc_in = 12'hA07;
    tick();
    check("sec_idx5_q", {4'd0, q}, 12'h0A5);
    check_err("sec_idx5_err", 2'b01);

    // Every single-bit flip is corrected, parity-bit flips included.
    for (int i = 0; i < 12; i++) begin
      hc_in = 12'hA27 ^ (12'h001 << i);
      tick();
      check("sec_sweep_q", {4'd0, q}, 12'h0A5);
      check_err("sec_sweep_err", 2'b01);
    end

    // Syndrome 13: passed through uncorrected.
    hc_in = 12'h806;
    tick();
    check("uncorr_q", {4'd0, q}, 12'h081);
    check_err("uncorr_err", 2'b10);

    // Clean loopback: q equals the byte presented two edges earlier.
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        rst   = 1'b1;
        data  = 8'($urandom_range(0, 255));
        hc_in = hc_out;
        tick();
        check("midrst_hc_out", hc_out, 12'h000);
        check("midrst_q", {4'd0, q}, 12'h000);
        check_err("midrst_err", 2'b00);
        rst = 1'b0;
        exp_q.delete();
        // After reset hc_out is zero, which decodes to zero on the next edge.
        exp_q.push_back(8'h00);
      end
      data  = 8'($urandom_range(0, 255));
      hc_in = hc_out;
      exp_q.push_back(data);
      tick();
      if (exp_q.size() >= 2) begin
        exp_v = exp_q.pop_front();
        check("loop_q", {4'd0, q}, {4'd0, exp_v});
        check_err("loop_err", 2'b00);
      end
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
